axis_lutram_fifo: RTL



---
 rtl/axis_lutram_fifo_pkg.sv | 20 ++
 rtl/axis_lutram_fifo_sdp_lut_ram.sv | 25 ++
 rtl/axis_lutram_fifo.sv | 81 ++++++++
 3 files changed

// File: rtl/axis_lutram_fifo_pkg.sv
// Shared pointer helpers for axis_lutram_fifo; optional tlast path is enabled by AXIS_LUTRAM_FIFO_TLAST_EN.
package axis_lutram_fifo_pkg;

    localparam int unsigned PTR_CMP_W = 16;

    function automatic logic ptrs_empty(input logic [PTR_CMP_W-1:0] wr_ptr,
                                        input logic [PTR_CMP_W-1:0] rd_ptr);
        return wr_ptr == rd_ptr;
    endfunction

    // Full means the wrap flags differ while the RAM address bits match.
    function automatic logic ptrs_full(input logic [PTR_CMP_W-1:0] wr_ptr,
                                       input logic [PTR_CMP_W-1:0] rd_ptr,
                                       input int unsigned           addr_width);
        logic [PTR_CMP_W-1:0] diff;
        diff = wr_ptr ^ rd_ptr;
        return diff == (PTR_CMP_W'(1) << addr_width);
    endfunction

endpackage

// File: rtl/axis_lutram_fifo_sdp_lut_ram.sv
// Simple dual-port LUT RAM: synchronous write, asynchronous read, contents never reset.
// Word width is set by the parent (wider when AXIS_LUTRAM_FIFO_TLAST_EN is defined).
module sdp_lut_ram #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_lutram_fifo.sv
// AXI-Stream FIFO around an SDP LUT RAM with 1-cycle fall-through and no output register.
// Define AXIS_LUTRAM_FIFO_TLAST_EN to carry tlast alongside tdata.
module axis_lutram_fifo
    import axis_lutram_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
`ifdef AXIS_LUTRAM_FIFO_TLAST_EN
    input  logic                  s_tlast,
    output logic                  m_tlast,
`endif
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
`ifdef AXIS_LUTRAM_FIFO_TLAST_EN
    localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
    localparam int unsigned WORD_W = DATA_WIDTH;
`endif

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              full, empty, push, pop;
    logic [WORD_W-1:0] wr_word, rd_word;

    assign empty = ptrs_empty(PTR_CMP_W'(wr_ptr_q), PTR_CMP_W'(rd_ptr_q));
    assign full  = ptrs_full(PTR_CMP_W'(wr_ptr_q), PTR_CMP_W'(rd_ptr_q), ADDR_WIDTH);

    assign s_tready = !full && !rst;
    assign m_tvalid = !empty;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    assign wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    // Modular subtraction gives occupancy directly, including across wrap.
    assign count = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

`ifdef AXIS_LUTRAM_FIFO_TLAST_EN
    assign wr_word = {s_tlast, s_tdata};
    assign m_tdata = rd_word[DATA_WIDTH-1:0];
    assign m_tlast = rd_word[DATA_WIDTH];
`else
    assign wr_word = s_tdata;
    assign m_tdata = rd_word;
`endif

    sdp_lut_ram #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (wr_word),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (rd_word)
    );

endmodule
